// File: rtl/sync_fifo_multimode.sv
// Single-clock FIFO with fill count, threshold flags, standard/FWFT read
// modes, sticky overflow/underflow and synchronous flush.
// Ports:
//   clk, rst           clock, async active-high reset
//   flush              sync clear of pointers, count and read data
//   winc, wData        write request and data
//   rinc, rData        read request (FWFT: pop) and read data
//   wFull, rEmpty      count == DEPTH / count == 0
//   almost_full        count >= AF_TH
//   almost_empty       count <= AE_TH
//   half_full          count >= DEPTH/2
//   count              fill level 0..DEPTH
//   overflow/underflow sticky access errors, cleared by clr_err
module sync_fifo_multimode #(
  parameter int DATA_SIZE = 12,
  parameter int ADDR_SIZE = 4,
  parameter int FWFT      = 0,
  parameter int AF_TH     = 14,
  parameter int AE_TH     = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 winc,
  input  logic [DATA_SIZE-1:0] wData,
  input  logic                 rinc,
  output logic [DATA_SIZE-1:0] rData,
  output logic                 wFull,
  output logic                 rEmpty,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic                 half_full,
  output logic [ADDR_SIZE:0]   count,
  output logic                 overflow,
  output logic                 underflow,
  input  logic                 clr_err
);

  localparam int DEPTH = 2 ** ADDR_SIZE;
  localparam int CW    = ADDR_SIZE + 1;

  localparam logic [ADDR_SIZE:0] DEPTH_C = CW'(DEPTH);
  localparam logic [ADDR_SIZE:0] AF_C    = CW'(AF_TH);
  localparam logic [ADDR_SIZE:0] AE_C    = CW'(AE_TH);
  localparam logic [ADDR_SIZE:0] HF_C    = CW'(DEPTH / 2);
  localparam logic [ADDR_SIZE:0] ONE_C   = CW'(1);

  logic [DATA_SIZE-1:0] mem_q [DEPTH];

  logic [ADDR_SIZE-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_SIZE-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_SIZE:0]   count_q, count_d;
  logic                 ovf_q, ovf_d;
  logic                 unf_q, unf_d;

  logic wr_acc;
  logic rd_acc;

  // Flags come straight from the registered count.
  assign wFull        = (count_q == DEPTH_C);
  assign rEmpty       = (count_q == '0);
  assign almost_full  = (count_q >= AF_C);
  assign almost_empty = (count_q <= AE_C);
  assign half_full    = (count_q >= HF_C);
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

  // Flush suppresses both accesses for its cycle.
  assign wr_acc = winc & ~wFull & ~flush;
  assign rd_acc = rinc & ~rEmpty & ~flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;
      unique case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + ONE_C;
        2'b01:   count_d = count_q - ONE_C;
        default: count_d = count_q;
      endcase
    end
  end

  // A new error outranks a clear arriving in the same cycle.
  always_comb begin
    ovf_d = (winc & wFull & ~flush) | (ovf_q & ~clr_err);
    unf_d = (rinc & rEmpty & ~flush) | (unf_q & ~clr_err);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // Storage is not reset; the rst gate keeps a write from landing
  // on an edge where reset is already asserted.
  always_ff @(posedge clk) begin
    if (!rst && wr_acc) mem_q[wr_ptr_q] <= wData;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head word is presented combinationally; zero while empty.
      assign rData = rEmpty ? '0 : mem_q[rd_ptr_q];
    end else begin : g_std
      logic [DATA_SIZE-1:0] rdata_q, rdata_d;

      always_comb begin
        rdata_d = rdata_q;
        if (flush)       rdata_d = '0;
        else if (rd_acc) rdata_d = mem_q[rd_ptr_q];
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) rdata_q <= '0;
        else     rdata_q <= rdata_d;
      end

      assign rData = rdata_q;
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_multimode.sv
// Testbench for sync_fifo_multimode: standard and FWFT instances share
// stimulus and are checked every cycle against a queue-based model.
module tb_sync_fifo_multimode;

  localparam int DW    = 12;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int AF    = 14;
  localparam int AE    = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          winc;
  logic [DW-1:0] wData;
  logic          rinc;
  logic          clr_err;

  logic [DW-1:0] s_rData, f_rData;
  logic          s_wFull, f_wFull;
  logic          s_rEmpty, f_rEmpty;
  logic          s_af, f_af;
  logic          s_ae, f_ae;
  logic          s_hf, f_hf;
  logic [AW:0]   s_count, f_count;
  logic          s_ovf, f_ovf;
  logic          s_unf, f_unf;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model
  logic [DW-1:0] mq[$];
  logic [DW-1:0] m_std_rd;
  logic          m_ovf;
  logic          m_unf;

  always #5 clk = ~clk;

  sync_fifo_multimode #(
    .DATA_SIZE(DW), .ADDR_SIZE(AW), .FWFT(0),
    .AF_TH(AF), .AE_TH(AE)
  ) u_std (
    .clk(clk), .rst(rst), .flush(flush),
    .winc(winc), .wData(wData), .rinc(rinc),
    .rData(s_rData), .wFull(s_wFull), .rEmpty(s_rEmpty),
    .almost_full(s_af), .almost_empty(s_ae),
    .half_full(s_hf), .count(s_count),
    .overflow(s_ovf), .underflow(s_unf),
    .clr_err(clr_err)
  );

  sync_fifo_multimode #(
    .DATA_SIZE(DW), .ADDR_SIZE(AW), .FWFT(1),
    .AF_TH(AF), .AE_TH(AE)
  ) u_fw (
    .clk(clk), .rst(rst), .flush(flush),
    .winc(winc), .wData(wData), .rinc(rinc),
    .rData(f_rData), .wFull(f_wFull), .rEmpty(f_rEmpty),
    .almost_full(f_af), .almost_empty(f_ae),
    .half_full(f_hf), .count(f_count),
    .overflow(f_ovf), .underflow(f_unf),
    .clr_err(clr_err)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    int n;
    logic [DW-1:0] fw_exp;
    n = mq.size();
    fw_exp = (n == 0) ? '0 : mq[0];
    chk({tag, ".s.count"}, 32'(s_count), 32'(n));
    chk({tag, ".f.count"}, 32'(f_count), 32'(n));
    chk({tag, ".s.full"},  32'(s_wFull), 32'(n == DEPTH));
    chk({tag, ".f.full"},  32'(f_wFull), 32'(n == DEPTH));
    chk({tag, ".s.empty"}, 32'(s_rEmpty), 32'(n == 0));
    chk({tag, ".f.empty"}, 32'(f_rEmpty), 32'(n == 0));
    chk({tag, ".s.af"},    32'(s_af), 32'(n >= AF));
    chk({tag, ".f.af"},    32'(f_af), 32'(n >= AF));
    chk({tag, ".s.ae"},    32'(s_ae), 32'(n <= AE));
    chk({tag, ".f.ae"},    32'(f_ae), 32'(n <= AE));
    chk({tag, ".s.hf"},    32'(s_hf), 32'(n >= DEPTH / 2));
    chk({tag, ".f.hf"},    32'(f_hf), 32'(n >= DEPTH / 2));
    chk({tag, ".s.ovf"},   32'(s_ovf), 32'(m_ovf));
    chk({tag, ".f.ovf"},   32'(f_ovf), 32'(m_ovf));
    chk({tag, ".s.unf"},   32'(s_unf), 32'(m_unf));
    chk({tag, ".f.unf"},   32'(f_unf), 32'(m_unf));
    chk({tag, ".s.rdata"}, 32'(s_rData), 32'(m_std_rd));
    chk({tag, ".f.rdata"}, 32'(f_rData), 32'(fw_exp));
  endtask

  task automatic model_reset();
    mq.delete();
    m_std_rd = '0;
    m_ovf    = 1'b0;
    m_unf    = 1'b0;
  endtask

  // Advance the model by one clock edge from the current inputs.
  task automatic model_edge();
    int  n;
    bit  full, empty, wa, ra;
    n     = mq.size();
    full  = (n == DEPTH);
    empty = (n == 0);
    if (winc && full && !flush) m_ovf = 1'b1;
    else if (clr_err)           m_ovf = 1'b0;
    if (rinc && empty && !flush) m_unf = 1'b1;
    else if (clr_err)            m_unf = 1'b0;
    if (flush) begin
      mq.delete();
      m_std_rd = '0;
    end else begin
      wa = winc && !full;
      ra = rinc && !empty;
      if (ra) m_std_rd = mq.pop_front();
      if (wa) mq.push_back(wData);
    end
  endtask

  task automatic step(input string tag,
                      input logic w, input logic [DW-1:0] d,
                      input logic r, input logic f,
                      input logic c);
    @(negedge clk);
    winc    = w;
    wData   = d;
    rinc    = r;
    flush   = f;
    clr_err = c;
    model_edge();
    @(posedge clk);
    #1;
    chk_all(tag);
  endtask

  initial begin
    rst     = 1'b1;
    flush   = 1'b0;
    winc    = 1'b0;
    rinc    = 1'b0;
    wData   = '0;
    clr_err = 1'b0;
    model_reset();
    #12;
    chk_all("reset");
    @(negedge clk);
    rst = 1'b0;

    for (int i = 1; i <= 16; i++)
      step("fill", 1'b1, DW'(i), 1'b0, 1'b0, 1'b0);
    step("ovf_wr", 1'b1, 12'hABC, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++)
      step("drain", 1'b0, '0, 1'b1, 1'b0, 1'b0);
    step("unf_rd", 1'b0, '0, 1'b1, 1'b0, 1'b0);
    step("clr", 1'b0, '0, 1'b0, 1'b0, 1'b1);

    for (int i = 0; i < 16; i++)
      step("fill2", 1'b1, 12'(12'h100 + i), 1'b0, 1'b0, 1'b0);
    step("full_wr", 1'b1, 12'h777, 1'b1, 1'b0, 1'b0);
    step("clr2", 1'b0, '0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++)
      step("inter", 1'b1, 12'($urandom), 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++)
      step("drain2", 1'b0, '0, 1'b1, 1'b0, 1'b0);
    step("empty_wr", 1'b1, 12'h321, 1'b1, 1'b0, 1'b0);
    step("pop", 1'b0, '0, 1'b1, 1'b0, 1'b1);

    step("fw_wr", 1'b1, 12'h5A5, 1'b0, 1'b0, 1'b0);
    step("fw_pop", 1'b0, '0, 1'b1, 1'b0, 1'b0);

    for (int i = 0; i < 5; i++)
      step("pre_fl", 1'b1, 12'(12'h0F0 + i), 1'b0, 1'b0, 1'b0);
    step("flush", 1'b1, 12'hEEE, 1'b1, 1'b1, 1'b0);
    step("post_fl", 1'b0, '0, 1'b1, 1'b0, 1'b0);

    for (int i = 0; i < 6; i++)
      step("burst", 1'b1, 12'($urandom), 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    winc  = 1'b1;
    wData = 12'h999;
    rinc  = 1'b1;
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    chk_all("rst_mid");
    @(posedge clk);
    #1;
    chk_all("rst_hold");
    @(negedge clk);
    rst  = 1'b0;
    winc = 1'b0;
    rinc = 1'b0;

    for (int i = 0; i < 400; i++)
      step("rand",
           1'($urandom_range(0, 1)),
           12'($urandom),
           1'($urandom_range(0, 1)),
           1'($urandom_range(0, 31) == 0),
           1'($urandom_range(0, 15) == 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
